ctrl_multicycle: RTL and testbench
==================================

// Module: ctrl_multicycle
// PURPOSE
//  Multicycle RV32I control unit; successor to the single-cycle ctrl decoder.
//  Moore FSM sequences fetch/decode/execute/memory/writeback over a shared
//  instruction/data memory, with parametrised memory wait states, bne support and an illegal-op trap.
//  Drives datapath mux selects, write strobes and ALUControl; sits beside the multicycle datapath.
// PARAMETERS
//  ALU_CTRL_W  3  width of ALUControl (codes zero-extended to this width; min 3)
//  MEM_LAT     0  extra wait cycles per memory access (FETCH, MEMREAD, MEMWRITE); 0..15
//  EN_BNE      1  1: funct3=001 branches on ~Zero; 0: funct3 ignored, branch on Zero only
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous, active-high reset
//  op          in   7           instruction opcode (from IR)
//  funct3      in   3           instruction funct3
//  funct7b5    in   1           instruction bit 30
//  Zero        in   1           ALU zero flag
//  PCWrite     out  1           PC register enable
//  AdrSrc      out  1           memory address: 0 = PC, 1 = ALUOut
//  MemWrite    out  1           data memory write strobe
//  IRWrite     out  1           instruction/OldPC register enable
//  RegWrite    out  1           register file write enable
//  ResultSrc   out  2           00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA     out  2           00 PC, 01 OldPC, 10 rs1
//  ALUSrcB     out  2           00 rs2, 01 ImmExt, 10 constant 4
//  ImmSrc      out  2           00 I, 01 S, 10 B, 11 J (combinational from op)
//  ALUControl  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
//  instr_done  out  1           1-cycle pulse on the last cycle of each instruction
//  trap        out  1           sticky: illegal opcode decoded
// BEHAVIOUR
//  - Reset: state<=FETCH, wait counter<=0, trap<=0; while rst=1 every strobe
//    (PCWrite, MemWrite, IRWrite, RegWrite, instr_done) is forced 0. Fetch begins on the first cycle after release.
//  - Per-state outputs (unlisted strobes 0, unlisted selects 00); next state:
//    FETCH    AdrSrc0 IRWrite A00 B10 ALUOp00 Res10 PCUpdate -> DECODE
//    DECODE   A01 B01 ALUOp00 -> lw/sw:MEMADR R(0110011):EXECR I(0010011):EXECI
//             jal:JAL beq-class(1100011):BRANCH other:ILLEGAL
//    MEMADR   A10 B01 ALUOp00 -> lw:MEMREAD, sw:MEMWRITE
//    MEMREAD  Res00 AdrSrc1 -> MEMWB;  MEMWB Res01 RegWrite -> FETCH
//    MEMWRITE Res00 AdrSrc1 MemWrite -> FETCH
//    EXECR    A10 B00 ALUOp10 -> ALUWB;  EXECI A10 B01 ALUOp10 -> ALUWB
//    ALUWB    Res00 RegWrite -> FETCH
//    JAL      A01 B10 ALUOp00 Res00 PCUpdate -> ALUWB
//    BRANCH   A10 B00 ALUOp01 Res00 Branch -> FETCH
//    ILLEGAL  trap=1, all strobes 0; held until rst
//  - PCWrite = PCUpdate | (Branch & take); take = (EN_BNE & funct3[0]) ? ~Zero : Zero.
//  - ALU decode: ALUOp00 add; 01 sub; 10 by funct3: 000 sub iff op[5]&funct7b5
//    else add, 010 slt, 110 or, 111 and; other funct3 -> add.
//  - Wait states: FETCH/MEMREAD/MEMWRITE last MEM_LAT+1 cycles; 4-bit counter
//    counts up, clears on exit. IRWrite, PCWrite and MemWrite pulse only on
//    the final cycle; selects held constant across all cycles of the state.
//  - Latency at MEM_LAT=0 (cycles FETCH..last): lw 5, sw/R/I/jal 4, branch 3;
//    each memory state adds MEM_LAT.
//  - instr_done=1 on the cycle whose next state is FETCH (not in ILLEGAL).
//  - Reset mid-instruction (e.g. in MEMWRITE): strobes drop the same cycle; no partial write.
// TESTING
//  1 MEM_LAT=0, op=0000011: states F,D,MA,MR,MWB; RegWrite=1 and Res=01 cycle 5 only, done cycle 5
//  2 op=0110011 f3=000 f7b5=1: ALUControl=001 in EXECR; f7b5=0 -> 000; f3=111 -> 010
//  3 op=1100011 f3=000 Zero=1 -> PCWrite=1 in BRANCH; f3=001 Zero=1 EN_BNE=1 -> PCWrite=0
//  4 MEM_LAT=2, sw: FETCH 3 cycles, IRWrite only cycle 3; MEMWRITE 3 cycles, MemWrite once
//  5 op=1111111 -> ILLEGAL after DECODE, trap=1 sticky, strobes 0; rst clears, FETCH next
//  6 rst=1 asserted during MEMWRITE: MemWrite=0 that cycle; FETCH on cycle after release

Source files
------------

// File: rtl/ctrl_multicycle.sv
// Multicycle RV32I control FSM: sequences fetch..writeback over a shared
// instruction/data memory, with memory wait states and an illegal-op trap.
module ctrl_multicycle #(
  parameter int ALU_CTRL_W = 3,
  parameter int MEM_LAT    = 0,
  parameter bit EN_BNE     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  instr_done,
  output logic                  trap
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [3:0] LAT    = 4'(MEM_LAT);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BRANCH,
    S_ILLEGAL
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_trap;

  logic       w_memst;
  logic       w_last;
  logic       w_fin;
  logic       w_pcupd;
  logic       w_branch;
  logic       w_irw;
  logic       w_memw;
  logic       w_regw;
  logic       w_adr;
  logic       w_take;
  logic [1:0] w_res;
  logic [1:0] w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_aluop;
  logic [2:0] w_alu3;

  // Only the memory-facing states stretch; all others finish in one cycle.
  assign w_memst = (r_state == S_FETCH) ||
                   (r_state == S_MEMREAD) ||
                   (r_state == S_MEMWRITE);
  assign w_last  = (r_cnt == LAT);
  assign w_fin   = !w_memst || w_last;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW,
          OP_SW:   w_next = S_MEMADR;
          OP_R:    w_next = S_EXECR;
          OP_I:    w_next = S_EXECI;
          OP_JAL:  w_next = S_JAL;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_BRANCH:   w_next = S_FETCH;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_trap  <= 1'b0;
    end else begin
      if (w_memst && !w_last) r_cnt <= r_cnt + 4'd1;
      else                    r_cnt <= '0;
      if (w_fin) r_state <= w_next;
      if (r_state == S_DECODE && w_next == S_ILLEGAL)
        r_trap <= 1'b1;
    end
  end

  always_comb begin
    w_pcupd  = 1'b0;
    w_branch = 1'b0;
    w_irw    = 1'b0;
    w_memw   = 1'b0;
    w_regw   = 1'b0;
    w_adr    = 1'b0;
    w_res    = 2'b00;
    w_srca   = 2'b00;
    w_srcb   = 2'b00;
    w_aluop  = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        w_irw   = w_last;
        w_pcupd = w_last;
        w_srcb  = 2'b10;
        w_res   = 2'b10;
      end
      S_DECODE: begin
        w_srca = 2'b01;
        w_srcb = 2'b01;
      end
      S_MEMADR: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
      end
      S_MEMREAD: w_adr = 1'b1;
      S_MEMWB: begin
        w_res  = 2'b01;
        w_regw = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr  = 1'b1;
        w_memw = w_last;
      end
      S_EXECR: begin
        w_srca  = 2'b10;
        w_aluop = 2'b10;
      end
      S_EXECI: begin
        w_srca  = 2'b10;
        w_srcb  = 2'b01;
        w_aluop = 2'b10;
      end
      S_ALUWB: w_regw = 1'b1;
      S_JAL: begin
        w_srca  = 2'b01;
        w_srcb  = 2'b10;
        w_pcupd = 1'b1;
      end
      S_BRANCH: begin
        w_srca   = 2'b10;
        w_aluop  = 2'b01;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu3 = 3'b000;
    unique case (w_aluop)
      2'b01: w_alu3 = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  w_alu3 = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu3 = 3'b101;
          3'b110:  w_alu3 = 3'b011;
          3'b111:  w_alu3 = 3'b010;
          default: w_alu3 = 3'b000;
        endcase
      end
      default: w_alu3 = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign w_take = (EN_BNE && funct3[0]) ? !Zero : Zero;

  // Strobes drop in the reset cycle itself so an interrupted store never lands.
  assign PCWrite    = !rst && (w_pcupd || (w_branch && w_take));
  assign IRWrite    = !rst && w_irw;
  assign MemWrite   = !rst && w_memw;
  assign RegWrite   = !rst && w_regw;
  assign instr_done = !rst && w_fin && (w_next == S_FETCH);

  assign AdrSrc     = w_adr;
  assign ResultSrc  = w_res;
  assign ALUSrcA    = w_srca;
  assign ALUSrcB    = w_srcb;
  assign ALUControl = ALU_CTRL_W'(w_alu3);
  assign trap       = r_trap;

endmodule

// File: tb/tb_ctrl_multicycle.sv
// Bench for ctrl_multicycle: two instances (MEM_LAT 0/bne on, MEM_LAT 2/bne off)
// checked cycle by cycle against per-instruction expected schedules.
module tb_ctrl_multicycle;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [17:0] SMASK = 18'h1B800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic [6:0] op[2];
  logic [2:0] f3[2];
  logic       f7[2];
  logic       zero[2];

  logic       pcw[2], adr[2], memw[2], irw[2], regw[2];
  logic [1:0] res[2], srca[2], srcb[2], imm[2];
  logic [2:0] alu[2];
  logic       done[2], trp[2];
  logic [17:0] ov[2];

  int ncmp = 0;
  int nerr = 0;

  ctrl_multicycle #(.ALU_CTRL_W(3), .MEM_LAT(0), .EN_BNE(1'b1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .op(op[0]), .funct3(f3[0]),
    .funct7b5(f7[0]), .Zero(zero[0]),
    .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemWrite(memw[0]),
    .IRWrite(irw[0]), .RegWrite(regw[0]), .ResultSrc(res[0]),
    .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .ImmSrc(imm[0]),
    .ALUControl(alu[0]), .instr_done(done[0]), .trap(trp[0])
  );

  ctrl_multicycle #(.ALU_CTRL_W(3), .MEM_LAT(2), .EN_BNE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .op(op[1]), .funct3(f3[1]),
    .funct7b5(f7[1]), .Zero(zero[1]),
    .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemWrite(memw[1]),
    .IRWrite(irw[1]), .RegWrite(regw[1]), .ResultSrc(res[1]),
    .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .ImmSrc(imm[1]),
    .ALUControl(alu[1]), .instr_done(done[1]), .trap(trp[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_pack
    assign ov[g] = {trp[g], done[g], pcw[g], adr[g], memw[g], irw[g],
                    regw[g], res[g], srca[g], srcb[g], imm[g], alu[g]};
  end

  typedef struct {
    bit         pcu, br, adr, memw, irw, regw, done, trap;
    logic [1:0] res, a, b;
    logic [2:0] alu;
  } exp_t;

  exp_t q[$];

  function automatic int lat_of(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic bit bne_of(int k);
    return (k == 0);
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f,
                                        logic s);
    case (f)
      3'b000:  return (o[5] && s) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BR)  return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic exp_t cyc(logic [1:0] a, logic [1:0] b,
                               logic [1:0] r, logic [2:0] al);
    exp_t e;
    e = '{default: '0};
    e.a = a; e.b = b; e.res = r; e.alu = al;
    return e;
  endfunction

  // Expected cycle-by-cycle schedule of one instruction.
  task automatic build(int k, logic [6:0] o, logic [2:0] f, logic s);
    exp_t e;
    int   l;
    l = lat_of(k);
    for (int c = 0; c <= l; c++) begin
      e = cyc(2'b00, 2'b10, 2'b10, 3'b000);
      e.pcu = (c == l); e.irw = (c == l);
      q.push_back(e);
    end
    q.push_back(cyc(2'b01, 2'b01, 2'b00, 3'b000));
    case (o)
      LW, SW: begin
        q.push_back(cyc(2'b10, 2'b01, 2'b00, 3'b000));
        for (int c = 0; c <= l; c++) begin
          e = cyc(2'b00, 2'b00, 2'b00, 3'b000);
          e.adr = 1'b1;
          if (o == SW) begin
            e.memw = (c == l); e.done = (c == l);
          end
          q.push_back(e);
        end
        if (o == LW) begin
          e = cyc(2'b00, 2'b00, 2'b01, 3'b000);
          e.regw = 1'b1; e.done = 1'b1;
          q.push_back(e);
        end
      end
      RT, IT, JAL: begin
        if (o == JAL) begin
          e = cyc(2'b01, 2'b10, 2'b00, 3'b000);
          e.pcu = 1'b1;
        end else begin
          e = cyc(2'b10, (o == IT) ? 2'b01 : 2'b00, 2'b00,
                  alu_of(o, f, s));
        end
        q.push_back(e);
        e = cyc(2'b00, 2'b00, 2'b00, 3'b000);
        e.regw = 1'b1; e.done = 1'b1;
        q.push_back(e);
      end
      BR: begin
        e = cyc(2'b10, 2'b00, 2'b00, 3'b001);
        e.br = 1'b1; e.done = 1'b1;
        q.push_back(e);
      end
      default: begin
        for (int c = 0; c < 4; c++) begin
          e = cyc(2'b00, 2'b00, 2'b00, 3'b000);
          e.trap = 1'b1;
          q.push_back(e);
        end
      end
    endcase
  endtask

  task automatic chk(string nm, logic [17:0] act, logic [17:0] want);
    ncmp++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Entered just after a rising edge with the DUT at the start of FETCH.
  task automatic run(int k, logic [6:0] o, logic [2:0] f, logic s,
                     int zm, output int n, output logic [17:0] o3,
                     output logic [17:0] last);
    exp_t        e;
    logic [17:0] ev;
    bit          take;
    int          idx;
    op[k] = o; f3[k] = f; f7[k] = s;
    build(k, o, f, s);
    n = q.size();
    idx = 0;
    o3 = '0;
    last = '0;
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      zero[k] = (zm < 0) ? 1'($urandom) : zm[0];
      @(negedge clk);
      take = (bne_of(k) && f[0]) ? !zero[k] : zero[k];
      ev = {e.trap, e.done, e.pcu | (e.br & take), e.adr, e.memw, e.irw,
            e.regw, e.res, e.a, e.b, imm_of(o), e.alu};
      chk($sformatf("dut%0d op=%b cyc%0d", k, o, idx), ov[k], ev);
      if (idx == 3) o3 = ov[k];
      last = ov[k];
      @(posedge clk); #1;
    end
    if (e.trap) begin
      rst[k] = 1'b1;
      @(negedge clk);
      chk($sformatf("dut%0d trap_rst_strobes", k), ov[k] & SMASK, '0);
      @(posedge clk); #1;
      rst[k] = 1'b0;
    end
  endtask

  task automatic rand_instr(int k);
    logic [6:0]  o;
    logic [17:0] a, b;
    int          n, r;
    logic [6:0]  bad[4];
    bad = '{7'b0010111, 7'b0110111, 7'b1100111, 7'b1111111};
    r = $urandom_range(0, 12);
    if (r < 2)       o = LW;
    else if (r < 4)  o = SW;
    else if (r < 6)  o = RT;
    else if (r < 8)  o = IT;
    else if (r < 9)  o = JAL;
    else if (r < 12) o = BR;
    else             o = bad[$urandom_range(0, 3)];
    run(k, o, 3'($urandom), 1'($urandom), -1, n, a, b);
  endtask

  initial begin
    int          n;
    logic [17:0] o3, last;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; op[k] = LW; f3[k] = '0; f7[k] = 1'b0; zero[k] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("reset_strobes0", ov[0] & SMASK, '0);
      chk("reset_strobes1", ov[1] & SMASK, '0);
      @(posedge clk);
    end
    chk("reset_trap0", 18'(trp[0]), '0);
    #1 rst[0] = 1'b0;

    run(0, LW, 3'b010, 1'b0, -1, n, o3, last);
    chk("lw_len", 18'(n), 18'd5);
    chk("lw_wb_regw", 18'(last[11]), 18'd1);
    chk("lw_wb_res", 18'(last[10:9]), 18'd1);
    chk("lw_wb_done", 18'(last[16]), 18'd1);
    run(0, RT, 3'b000, 1'b1, -1, n, o3, last);
    chk("r_len", 18'(n), 18'd4);
    chk("r_sub", 18'(o3[2:0]), 18'b001);
    run(0, RT, 3'b000, 1'b0, -1, n, o3, last);
    chk("r_add", 18'(o3[2:0]), 18'b000);
    run(0, RT, 3'b111, 1'b0, -1, n, o3, last);
    chk("r_and", 18'(o3[2:0]), 18'b010);
    run(0, BR, 3'b000, 1'b0, 1, n, o3, last);
    chk("beq_len", 18'(n), 18'd3);
    chk("beq_taken", 18'(o3[15]), 18'd1);
    run(0, BR, 3'b001, 1'b0, 1, n, o3, last);
    chk("bne_not_taken", 18'(o3[15]), 18'd0);
    run(0, 7'b1111111, 3'b000, 1'b0, -1, n, o3, last);
    chk("illegal_trap", 18'(o3[17]), 18'd1);
    chk("illegal_strobes", o3 & SMASK, '0);
    for (int i = 0; i < 60; i++) rand_instr(0);

    rst[0] = 1'b1;
    rst[1] = 1'b0;
    run(1, SW, 3'b010, 1'b0, -1, n, o3, last);
    chk("sw_lat2_len", 18'(n), 18'd8);
    chk("sw_lat2_irw_c3", 18'(o3[12]), 18'd1);
    chk("sw_lat2_memw_last", 18'(last[13]), 18'd1);
    run(1, BR, 3'b001, 1'b0, 1, n, o3, last);
    chk("bne_off_taken", 18'(last[15]), 18'd1);

    op[1] = SW; f3[1] = 3'b010;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) begin
        chk("mw_entered_adr", 18'(adr[1]), 18'd1);
        chk("mw_no_early_write", 18'(memw[1]), 18'd0);
      end
      @(posedge clk); #1;
    end
    rst[1] = 1'b1;
    @(negedge clk);
    chk("rst_in_memwrite", ov[1] & SMASK, '0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 60; i++) rand_instr(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
